// File: rtl/pe_pkg.sv
// Shared definitions for the priority-encoder event queue.
package pe_pkg;

    localparam int unsigned PE_CODE_W = 3;
    localparam int unsigned PE_DEPTH  = 4;
    localparam int unsigned PE_PTR_W  = $clog2(PE_DEPTH);
    localparam int unsigned PE_CNT_W  = PE_PTR_W + 1;

    // Per-cycle FIFO operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/pe_code_fifo.sv
// Circular buffer of encoded indices with occupancy counter.
module pe_code_fifo
    import pe_pkg::*;
#(
    parameter int unsigned DEPTH  = PE_DEPTH,
    parameter int unsigned CODE_W = PE_CODE_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] wr_data,
    output logic [CODE_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full buffer is only legal when a pop frees a slot this cycle.
    assign push_ok = push & (~full | pop_ok);
    assign count   = count_q;
    // Head reads 0 when empty so stale storage never shows after reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case (fifo_op(push_ok, pop_ok))
            OpPush:  count_d = count_q + CNT_W'(1);
            OpPop:   count_d = count_q - CNT_W'(1);
            OpNone,
            OpBoth:  count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pe_event_queue.sv
// Turns changes of the priority-encoder output into queued events.
module pe_event_queue
    import pe_pkg::*;
#(
    parameter int unsigned DEPTH  = PE_DEPTH,
    parameter int unsigned CODE_W = PE_CODE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CODE_W-1:0]      code_in,
    input  logic                   code_vld,
    output logic [CODE_W-1:0]      out_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    logic [CODE_W-1:0] prev_code_q, prev_code_d;
    logic              prev_vld_q, prev_vld_d;
    logic              overflow_q, overflow_d;
    logic              evt;
    logic              pop;
    logic              push;
    logic              drop;

    // A held code produces one event; valid->invalid produces none.
    assign evt       = code_vld & (~prev_vld_q | (code_in != prev_code_q));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = evt & (~full | pop);
    assign drop      = evt & full & ~pop;
    assign overflow  = overflow_q;

    pe_code_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (code_in),
        .rd_data (out_code),
        .count   (count),
        .full    (full)
    );

    // Next-state for change detection and sticky overflow; a drop beats a clear.
    always_comb begin
        prev_code_d = code_in;
        prev_vld_d  = code_vld;
        overflow_d  = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Change-detection and overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_code_q <= '0;
            prev_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_code_q <= prev_code_d;
            prev_vld_q  <= prev_vld_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pe_event_queue.sv
// Bench for pe_event_queue: directed vector table plus randomized run vs. a queue model.
module tb_pe_event_queue;

    localparam int DEPTH  = 4;
    localparam int CODE_W = 3;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] code_in;
    logic              code_vld;
    logic [CODE_W-1:0] out_code;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;
    logic              clr_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_event_queue #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .code_vld  (code_vld),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // Inputs for one cycle and the outputs expected after that cycle's edge.
    typedef struct {
        logic rst_n;
        logic vld;
        int   code;
        logic rdy;
        logic clr;
        int   e_cnt;
        int   e_code;
        logic e_ovf;
        string tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic r, input logic v, input int c,
                       input logic rd, input logic cl, input int ec, input int ecode,
                       input logic eovf);
        vec_t x;
        x.tag = tag; x.rst_n = r; x.vld = v; x.code = c; x.rdy = rd; x.clr = cl;
        x.e_cnt = ec; x.e_code = ecode; x.e_ovf = eovf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, leave outputs ready to sample.
    task automatic apply(input logic r, input logic v, input int c, input logic rd,
                         input logic cl);
        rst_n = r; code_vld = v; code_in = CODE_W'(c); out_ready = rd; clr_ovf = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ec, input int ecode, input logic eovf);
        chk({tag, ".count"},     32'(count),     32'(ec));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ec > 0));
        chk({tag, ".full"},      32'(full),      32'(ec == DEPTH));
        chk({tag, ".out_code"},  32'(out_code),  32'(ecode));
        chk({tag, ".overflow"},  32'(overflow),  32'(eovf));
    endtask

    // Behavioural reference: event/FIFO rules expressed on a plain queue.
    int   mq[$];
    logic m_pv;
    int   m_pc;
    logic m_ovf;

    task automatic model_step(input logic r, input logic v, input int c, input logic rd,
                              input logic cl);
        logic ev, was_full, popped;
        if (!r) begin
            mq.delete();
            m_pv = 1'b0; m_pc = 0; m_ovf = 1'b0;
            return;
        end
        ev       = v && (!m_pv || c != m_pc);
        was_full = (mq.size() == DEPTH);
        popped   = (mq.size() > 0) && rd;
        if (popped) void'(mq.pop_front());
        if (ev && (!was_full || popped)) mq.push_back(c);
        if (ev && was_full && !popped) m_ovf = 1'b1;
        else if (cl) m_ovf = 1'b0;
        m_pv = v; m_pc = c;
    endtask

    initial begin
        rst_n = 1'b0; code_vld = 1'b0; code_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        // Reset, then one held code yields exactly one entry.
        add("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        add("hold5_first", 1, 1, 5, 0, 0, 1, 5, 0);
        for (int i = 0; i < 9; i++) add("hold5", 1, 1, 5, 0, 0, 1, 5, 0);
        add("pop5", 1, 0, 0, 1, 0, 0, 0, 0);
        // Fill, drop the fifth, drain in order, then clear the sticky flag.
        add("f1", 1, 1, 1, 0, 0, 1, 1, 0);
        add("f2", 1, 1, 2, 0, 0, 2, 1, 0);
        add("f3", 1, 1, 3, 0, 0, 3, 1, 0);
        add("f4", 1, 1, 4, 0, 0, 4, 1, 0);
        add("drop6", 1, 1, 6, 0, 0, 4, 1, 1);
        add("d1", 1, 0, 0, 1, 0, 3, 2, 1);
        add("d2", 1, 0, 0, 1, 0, 2, 3, 1);
        add("d3", 1, 0, 0, 1, 0, 1, 4, 1);
        add("d4", 1, 0, 0, 1, 0, 0, 0, 1);
        add("clr", 1, 0, 0, 0, 1, 0, 0, 0);
        // Full queue with simultaneous push and pop.
        add("g1", 1, 1, 1, 0, 0, 1, 1, 0);
        add("g2", 1, 1, 2, 0, 0, 2, 1, 0);
        add("g3", 1, 1, 3, 0, 0, 3, 1, 0);
        add("g4", 1, 1, 4, 0, 0, 4, 1, 0);
        add("push7pop", 1, 1, 7, 1, 0, 4, 2, 0);
        add("e1", 1, 0, 0, 1, 0, 3, 3, 0);
        add("e2", 1, 0, 0, 1, 0, 2, 4, 0);
        add("e3", 1, 0, 0, 1, 0, 1, 7, 0);
        add("e4", 1, 0, 0, 1, 0, 0, 0, 0);
        // Alternating valid/invalid with a ready consumer.
        for (int i = 0; i < 4; i++) begin
            add("alt_v", 1, 1, 3, 1, 0, 1, 3, 0);
            add("alt_n", 1, 0, 3, 1, 0, 0, 0, 0);
        end
        // Reset mid-operation with an event present.
        add("r1", 1, 1, 1, 0, 0, 1, 1, 0);
        add("r2", 1, 1, 2, 0, 0, 2, 1, 0);
        add("r3", 1, 1, 3, 0, 0, 3, 1, 0);
        add("rst_mid", 0, 1, 5, 0, 0, 0, 0, 0);
        add("post_rst_idle", 1, 0, 5, 0, 0, 0, 0, 0);
        // First valid cycle after reset is an event even with the same code.
        add("rst_b", 0, 1, 5, 0, 0, 0, 0, 0);
        add("post_rst_evt", 1, 1, 5, 0, 0, 1, 5, 0);
        add("post_rst_pop", 1, 0, 0, 1, 0, 0, 0, 0);
        // Drop and clear in the same cycle: set wins; clear alone next.
        add("h1", 1, 1, 1, 0, 0, 1, 1, 0);
        add("h2", 1, 1, 2, 0, 0, 2, 1, 0);
        add("h3", 1, 1, 3, 0, 0, 3, 1, 0);
        add("h4", 1, 1, 4, 0, 0, 4, 1, 0);
        add("drop_clr", 1, 1, 6, 0, 1, 4, 1, 1);
        add("clr_only", 1, 0, 0, 0, 1, 4, 1, 0);
        add("k1", 1, 0, 0, 1, 0, 3, 2, 0);
        add("k2", 1, 0, 0, 1, 0, 2, 3, 0);
        add("k3", 1, 0, 0, 1, 0, 1, 4, 0);
        add("k4", 1, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].vld, vecs[i].code, vecs[i].rdy, vecs[i].clr);
            chk_all(vecs[i].tag, vecs[i].e_cnt, vecs[i].e_code, vecs[i].e_ovf);
        end

        // Stable head while stalled.
        apply(1, 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0);
            chk("stall.out_code", 32'(out_code), 32'd2);
        end

        // Randomized run against the queue model.
        apply(0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0);
        chk_all("rnd_rst", mq.size(), 0, m_ovf);
        for (int i = 0; i < 3000; i++) begin
            logic r, v, rd, cl;
            int   c;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = $urandom_range(0, 3);
            rd = ($urandom_range(0, 2) == 0);
            cl = ($urandom_range(0, 7) == 0);
            apply(r, v, c, rd, cl);
            model_step(r, v, c, rd, cl);
            chk_all("rnd", mq.size(), (mq.size() > 0) ? mq[0] : 0, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
